subwordread_spill: RTL and testbench

Parametrised successor to the load subword extractor. It accepts one load request, fetches one or two LLEN-wide memory beats over a valid/ready handshake, and assembles loads that cross an LLEN word boundary from both beats. It then extracts, sign-extends or NaN-boxes the data, and returns it through a registered valid/ready response port. It sits in the LSU between the data-cache/bus read path and the writeback mux.

---
 rtl/subwordread_spill_if.sv | 43 ++++
 rtl/subwordread_spill.sv | 175 +++++++++++++++++
 tb/tb_subwordread_spill.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/subwordread_spill_if.sv
// subwordread_spill_if
// Bundles the request, memory-beat and response handshakes of the load
// subword extractor.
//   slave  : the extractor itself (accepts requests and beats, drives responses)
//   master : the surrounding LSU / memory path (drives requests and beats)
// Request : ReqValid/ReqReady, PAdr, Funct3, FpLoadStore, BigEndian
// Beat    : BeatValid/BeatReady, BeatSel, BeatData
// Response: RspValid/RspReady, RspData, RspSpill, RspErr
interface subwordread_spill_if #(
    parameter int LLEN = 64
);
    localparam int OW = $clog2(LLEN / 8);

    logic            ReqValid;
    logic            ReqReady;
    logic [OW-1:0]   PAdr;
    logic [2:0]      Funct3;
    logic            FpLoadStore;
    logic            BigEndian;
    logic            BeatValid;
    logic            BeatReady;
    logic            BeatSel;
    logic [LLEN-1:0] BeatData;
    logic            RspValid;
    logic            RspReady;
    logic [LLEN-1:0] RspData;
    logic            RspSpill;
    logic            RspErr;

    modport slave (
        input  ReqValid, PAdr, Funct3, FpLoadStore, BigEndian,
        input  BeatValid, BeatData, RspReady,
        output ReqReady, BeatReady, BeatSel,
        output RspValid, RspData, RspSpill, RspErr
    );

    modport master (
        output ReqValid, PAdr, Funct3, FpLoadStore, BigEndian,
        output BeatValid, BeatData, RspReady,
        input  ReqReady, BeatReady, BeatSel,
        input  RspValid, RspData, RspSpill, RspErr
    );
endinterface

// File: rtl/subwordread_spill.sv
// subwordread_spill
// Accepts one load request, fetches one or two LLEN-wide beats, assembles
// loads that cross a word boundary, then extracts and sign-extends /
// NaN-boxes / zero-extends the result and returns it on a registered
// response port.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : subwordread_spill_if.slave (request, beat and response handshakes)
//
// state | meaning
// IDLE  | waiting for a request (ReqReady=1)
// BEAT0 | fetching the word at PAdr
// BEAT1 | fetching the following word (spilling access only)
// RESP  | response valid, held until RspReady
module subwordread_spill #(
    parameter int LLEN = 64
) (
    input  logic clk,
    input  logic reset,
    subwordread_spill_if.slave bus
);
    localparam int NB = LLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [OW:0] NB_W = (OW+1)'(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state, next_state;

    logic [OW-1:0]   padr_q;
    logic [2:0]      size_q;
    logic            uns_q, fp_q, be_q, spill_q;
    logic [LLEN-1:0] w0, w1;
    logic [LLEN-1:0] rsp_data;
    logic            rsp_spill, rsp_err;

    // request decode
    logic        is_flq, req_err, req_spill;
    logic [2:0]  req_size;
    logic [7:0]  req_n;
    logic [OW:0] req_end;

    always_comb begin
        is_flq   = (bus.Funct3 == 3'b100) && bus.FpLoadStore && (LLEN == 128);
        req_size = is_flq ? 3'd4 : {1'b0, bus.Funct3[1:0]};
        req_n    = 8'd1 << req_size;
        req_err  = (req_n > 8'(NB)) || (bus.Funct3 == 3'b111) ||
                   (bus.BigEndian && ((8'(bus.PAdr) & (req_n - 8'd1)) != 8'd0)) ||
                   ((bus.Funct3 == 3'b110) && (LLEN == 32));
        // only meaningful when req_n <= NB, which always holds when not an error
        req_end   = {1'b0, bus.PAdr} + req_n[OW:0];
        req_spill = !req_err && (req_end > NB_W);
    end

    // FSM
    logic accept, beat0_hs, beat1_hs, rsp_hs;
    logic req_ready, beat_ready, beat_sel, rsp_valid;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        beat_ready = 1'b0;
        beat_sel   = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.ReqValid) next_state = req_err ? RESP : BEAT0;
            end
            BEAT0: begin
                beat_ready = 1'b1;
                if (bus.BeatValid) next_state = spill_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                beat_ready = 1'b1;
                beat_sel   = 1'b1;
                if (bus.BeatValid) next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.RspReady) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            req_ready  = 1'b0;
            beat_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    assign accept   = (state == IDLE) && bus.ReqValid;
    assign beat0_hs = (state == BEAT0) && bus.BeatValid;
    assign beat1_hs = (state == BEAT1) && bus.BeatValid;
    assign rsp_hs   = (state == RESP) && bus.RspReady;

    // extraction: the beat arriving this cycle is used directly so the
    // result can be registered on the same edge that enters RESP
    logic [LLEN-1:0]   ex_w0, ex_w1, raw, ext;
    logic [2*LLEN-1:0] window;
    logic [7:0]        n_q;
    logic [OW:0]       eff_off;
    logic              top_bit, fill_bit;

    always_comb begin
        n_q     = 8'd1 << size_q;
        eff_off = be_q ? (NB_W - n_q[OW:0] - {1'b0, padr_q}) : {1'b0, padr_q};
        ex_w0   = (state == BEAT0) ? bus.BeatData : w0;
        ex_w1   = (state == BEAT1) ? bus.BeatData : w1;
        window  = {(spill_q ? ex_w1 : {LLEN{1'b0}}), ex_w0};
        raw     = LLEN'(window >> {eff_off, 3'b000});
        top_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i + 1 == int'(n_q)) top_bit = raw[8*i+7];
        end
        fill_bit = fp_q | (~uns_q & top_bit);
        ext = '0;
        for (int i = 0; i < NB; i++) begin
            ext[8*i +: 8] = (i < int'(n_q)) ? raw[8*i +: 8] : {8{fill_bit}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            padr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            fp_q      <= 1'b0;
            be_q      <= 1'b0;
            spill_q   <= 1'b0;
            w0        <= '0;
            w1        <= '0;
            rsp_data  <= '0;
            rsp_spill <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                padr_q  <= bus.PAdr;
                size_q  <= req_size;
                uns_q   <= bus.Funct3[2];
                fp_q    <= bus.FpLoadStore;
                be_q    <= bus.BigEndian;
                spill_q <= req_spill;
                if (req_err) begin
                    rsp_data  <= '0;
                    rsp_spill <= 1'b0;
                    rsp_err   <= 1'b1;
                end
            end
            if (beat0_hs) w0 <= bus.BeatData;
            if (beat1_hs) w1 <= bus.BeatData;
            if ((beat0_hs && !spill_q) || beat1_hs) begin
                rsp_data  <= ext;
                rsp_spill <= spill_q;
                rsp_err   <= 1'b0;
            end
        end
    end

    assign bus.ReqReady  = req_ready;
    assign bus.BeatReady = beat_ready;
    assign bus.BeatSel   = beat_sel;
    assign bus.RspValid  = rsp_valid;
    assign bus.RspData   = rsp_data;
    assign bus.RspSpill  = rsp_spill;
    assign bus.RspErr    = rsp_err;

    logic unused_ok;
    assign unused_ok = rsp_hs;
endmodule

// File: tb/tb_subwordread_spill.sv
// tb_subwordread_spill
// Scoreboard bench: each load pushes its modelled result, a negedge monitor
// pops and compares on every response handshake. A second instance with
// LLEN=128 covers the flq path.
module tb_subwordread_spill;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    subwordread_spill_if #(.LLEN(64))  b64 ();
    subwordread_spill_if #(.LLEN(128)) b128 ();

    subwordread_spill #(.LLEN(64))  dut64  (.clk(clk), .reset(reset), .bus(b64.slave));
    subwordread_spill #(.LLEN(128)) dut128 (.clk(clk), .reset(reset), .bus(b128.slave));

    typedef struct {
        logic [63:0] d;
        logic        s;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beat_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input int llen, input logic [2:0] f3, input bit fp, input bit be,
                                  input int padr, input logic [127:0] b0, input logic [127:0] b1,
                                  output logic [127:0] d, output bit sp, output bit er);
        int nb, n, off;
        bit fl, top;
        logic [7:0] win [32];
        nb = llen / 8;
        fl = (f3 == 3'b100) && fp && (llen == 128);
        n  = fl ? 16 : (1 << f3[1:0]);
        er = (n > nb) || (f3 == 3'b111) || (be && (padr % n) != 0) || (f3 == 3'b110 && llen == 32);
        sp = !er && (padr + n > nb);
        d  = '0;
        if (!er) begin
            for (int i = 0; i < nb; i++) begin
                win[i]      = b0[8*i +: 8];
                win[nb + i] = sp ? b1[8*i +: 8] : 8'h00;
            end
            off = be ? nb - n - padr : padr;
            for (int i = 0; i < n; i++) d[8*i +: 8] = win[off + i];
            top = d[8*n-1];
            for (int i = n; i < nb; i++) d[8*i +: 8] = (fp || (!f3[2] && top)) ? 8'hFF : 8'h00;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (b64.BeatValid && b64.BeatReady) beat_hs++;
        if (b64.RspValid && b64.RspReady) begin
            if (sb.size() == 0) chk("unexpected_rsp", b64.RspValid, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_data", b64.RspData, e.d);
                chk("rsp_spill", b64.RspSpill, e.s);
                chk("rsp_err", b64.RspErr, e.e);
            end
        end
    end

    task automatic send_req(input logic [2:0] f3, input bit fp, input bit be, input int padr, output int a);
        int t;
        @(posedge clk); #1;
        b64.ReqValid = 1'b1; b64.Funct3 = f3; b64.FpLoadStore = fp;
        b64.BigEndian = be; b64.PAdr = 3'(padr);
        t = 0;
        @(negedge clk);
        while (!b64.ReqReady && t < 20) begin @(negedge clk); t++; end
        chk("req_ready", b64.ReqReady, 1);
        a = cyc;
        @(posedge clk); #1;
        b64.ReqValid = 1'b0;
    endtask

    task automatic send_beat(input bit sel, input logic [63:0] data, input int gap);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        b64.BeatValid = 1'b1; b64.BeatData = data;
        @(negedge clk);
        chk("beat_ready", b64.BeatReady, 1);
        chk("beat_sel", b64.BeatSel, sel);
        @(posedge clk); #1;
        b64.BeatValid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input bit fp, input bit be, input int padr,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input int g0, input int g1, input int rg);
        logic [127:0] md;
        bit ms, me;
        int a, hs, t;
        exp_t e;
        model(64, f3, fp, be, padr, {64'h0, d0}, {64'h0, d1}, md, ms, me);
        e.d = md[63:0]; e.s = ms; e.e = me;
        sb.push_back(e);
        send_req(f3, fp, be, padr, a);
        hs = beat_hs;
        if (rg == 0) b64.RspReady = 1'b1;
        if (me) b64.BeatValid = 1'b1;
        else begin
            send_beat(1'b0, d0, g0);
            if (ms) send_beat(1'b1, d1, g1);
        end
        t = 0;
        @(negedge clk);
        while (!b64.RspValid && t < 30) begin @(negedge clk); t++; end
        chk("rsp_seen", b64.RspValid, 1);
        chk("latency", 128'(cyc - a), 128'(me ? 1 : (ms ? 3 + g0 + g1 : 2 + g0)));
        chk("req_ready_in_resp", b64.ReqReady, 0);
        if (me) chk("err_no_beat", 128'(beat_hs - hs), 0);
        if (rg > 0) begin
            repeat (rg - 1) begin
                chk("hold_data", b64.RspData, md[63:0]);
                @(negedge clk);
            end
            chk("hold_data", b64.RspData, md[63:0]);
            @(posedge clk); #1;
            b64.RspReady = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        b64.RspReady = 1'b0;
        b64.BeatValid = 1'b0;
        @(negedge clk);
        chk("idle_after", {b64.ReqReady, b64.RspValid}, 2'b10);
    endtask

    localparam logic [63:0] D = 64'h8877665544332211;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, hs;
        logic [127:0] q0, q1, qd;
        bit qs, qe;
        reset = 1'b1;
        b64.ReqValid = 0; b64.PAdr = 0; b64.Funct3 = 0; b64.FpLoadStore = 0; b64.BigEndian = 0;
        b64.BeatValid = 0; b64.BeatData = 0; b64.RspReady = 0;
        b128.ReqValid = 0; b128.PAdr = 0; b128.Funct3 = 0; b128.FpLoadStore = 0; b128.BigEndian = 0;
        b128.BeatValid = 0; b128.BeatData = 0; b128.RspReady = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", b64.ReqReady, 0);
        chk("rst_beat_ready", b64.BeatReady, 0);
        chk("rst_rsp_valid", b64.RspValid, 0);
        chk("rst_rsp_data", b64.RspData, 0);
        chk("rst_rsp_spill", b64.RspSpill, 0);
        chk("rst_rsp_err", b64.RspErr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed loads (f3, fp, be, padr, beat0, beat1, gap0, gap1, rsp gap)
        do_load(3'b001, 0, 0, 2, D, 64'h0, 0, 0, 0);                  // lh
        do_load(3'b010, 0, 0, 6, D, 64'h00000000CCBBAA99, 0, 0, 0);   // lw spill
        do_load(3'b010, 1, 0, 0, D, 64'h0, 0, 0, 0);                  // flw
        do_load(3'b100, 0, 0, 7, D, 64'h0, 0, 0, 0);                  // lbu
        do_load(3'b110, 0, 0, 4, D, 64'h0, 0, 0, 0);                  // lwu
        do_load(3'b000, 0, 1, 0, D, 64'h0, 0, 0, 0);                  // BE lb
        do_load(3'b001, 0, 1, 1, D, 64'h0, 0, 0, 0);                  // BE lh misaligned
        do_load(3'b111, 0, 0, 0, D, 64'h0, 0, 0, 1);                  // illegal funct3
        do_load(3'b011, 0, 0, 0, D, 64'h0, 0, 0, 0);                  // ld, full width
        do_load(3'b011, 0, 0, 3, D, 64'h0123456789ABCDEF, 0, 3, 5);   // backpressure
        do_load(3'b001, 0, 0, 7, 64'h80FFFFFFFFFFFFFF, 64'h55, 2, 1, 2); // lh spill

        for (int i = 0; i < 24; i++) begin
            logic [2:0] f3;
            bit fp;
            f3 = 3'($urandom_range(0, 7));
            fp = (f3 == 3'b010 || f3 == 3'b011) ? 1'($urandom_range(0, 1)) : 1'b0;
            do_load(f3, fp, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // reset pulsed in BEAT1 abandons the access
        send_req(3'b010, 0, 0, 6, a);
        send_beat(1'b0, D, 0);
        hs = beat_hs;
        reset = 1'b1;
        b64.BeatValid = 1'b1; b64.BeatData = 64'hCCBBAA99;
        @(negedge clk);
        chk("rst_mid_beat_ready", b64.BeatReady, 0);
        chk("rst_mid_req_ready", b64.ReqReady, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        b64.BeatValid = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", b64.ReqReady, 1);
        chk("rst_mid_data", b64.RspData, 0);
        repeat (4) begin
            chk("rst_mid_no_rsp", b64.RspValid, 0);
            @(negedge clk);
        end
        chk("rst_mid_no_beat", 128'(beat_hs - hs), 0);

        // flq on the 128-bit instance
        q0 = {$urandom, $urandom, $urandom, $urandom};
        q1 = {$urandom, $urandom, $urandom, $urandom};
        model(128, 3'b100, 1, 0, 8, q0, q1, qd, qs, qe);
        @(posedge clk); #1;
        b128.ReqValid = 1'b1; b128.Funct3 = 3'b100; b128.FpLoadStore = 1'b1; b128.PAdr = 4'd8;
        @(negedge clk);
        chk("q_req_ready", b128.ReqReady, 1);
        @(posedge clk); #1;
        b128.ReqValid = 1'b0; b128.BeatValid = 1'b1; b128.BeatData = q0;
        @(negedge clk);
        chk("q_beat_sel0", {b128.BeatReady, b128.BeatSel}, 2'b10);
        @(posedge clk); #1;
        b128.BeatData = q1;
        @(negedge clk);
        chk("q_beat_sel1", {b128.BeatReady, b128.BeatSel}, 2'b11);
        @(posedge clk); #1;
        b128.BeatValid = 1'b0; b128.RspReady = 1'b1;
        @(negedge clk);
        chk("q_rsp_valid", b128.RspValid, 1);
        chk("q_rsp_data", b128.RspData, qd);
        chk("q_rsp_bytes", b128.RspData, {q1[63:0], q0[127:64]});
        chk("q_rsp_spill", b128.RspSpill, 1);
        chk("q_rsp_err", b128.RspErr, 0);
        @(posedge clk); #1;
        b128.RspReady = 1'b0;
        @(negedge clk);
        chk("q_idle_after", {b128.ReqReady, b128.RspValid}, 2'b10);

        chk("sb_drained", 128'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
